// File: rtl/ifft2d_corner_turn_pkg.sv
// Shared types, default geometry and sizing helper for the 2D IDFT corner turn.
package ifft_pkg;

  localparam int unsigned DEF_DATALEN = 16;
  localparam int unsigned DEF_ROWS    = 8;
  localparam int unsigned DEF_COLS    = 8;
  localparam int unsigned DEF_OUTLEN  = 8;
  localparam int unsigned DEF_PTS     = 2;

  localparam int unsigned CMPLXLEN = 2 * DEF_DATALEN;

  typedef struct packed {
    logic [DEF_DATALEN-1:0] im;
    logic [DEF_DATALEN-1:0] re;
  } complex_t;

  // Counter width for values 0..v-1; never less than 1 bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ifft2d_corner_turn_bank.sv
// One ROWS x COLS complex register bank: row write port, valid-row count capture
// and column-group read mux with zero padding beyond the written rows.
module ct_bank
  import ifft_pkg::*;
#(
  parameter int unsigned DATALEN = DEF_DATALEN,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned OUTLEN  = DEF_OUTLEN,
  parameter int unsigned PTS     = DEF_PTS,
  localparam int unsigned CW     = 2 * DATALEN,
  localparam int unsigned RW     = clog2(ROWS),
  localparam int unsigned VW     = clog2(ROWS + 1),
  localparam int unsigned BW     = clog2(OUTLEN / PTS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_wr_en,
  input  logic [RW-1:0]            i_wr_row,
  input  logic [COLS*CW-1:0]       i_wr_data,
  input  logic                     i_close,
  input  logic [VW-1:0]            i_rows_valid,
  input  logic [BW-1:0]            i_beat,
  output logic [COLS*PTS*CW-1:0]   o_rd_data
);

  logic [COLS*CW-1:0] r_mem [ROWS];
  logic [VW-1:0]      r_rows_valid;

  // Sample storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_row] <= i_wr_data;
  end

  // Number of rows actually written in the frame that closed into this bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        r_rows_valid <= '0;
    else if (i_close) r_rows_valid <= i_rows_valid;
  end

  // Gather PTS consecutive rows for every lane; unwritten or pad rows read as zero.
  always_comb begin
    o_rd_data = '0;
    for (int unsigned p = 0; p < PTS; p++) begin
      int unsigned row;
      row = 32'(i_beat) * PTS + p;
      if (row < ROWS && row < 32'(r_rows_valid)) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          o_rd_data[(c*PTS+p)*CW +: CW] = r_mem[RW'(row)][c*CW +: CW];
        end
      end
    end
  end

endmodule

// File: rtl/ifft2d_corner_turn.sv
// Double-buffered corner turn between the row IDFT and the column IDFT bank:
// rows in, column groups of PTS row-points per lane out, with handshakes both sides.
module ifft2d_corner_turn
  import ifft_pkg::*;
#(
  parameter int unsigned DATALEN = DEF_DATALEN,
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned OUTLEN  = DEF_OUTLEN,
  parameter int unsigned PTS     = DEF_PTS,
  localparam int unsigned CW     = 2 * DATALEN
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [COLS*CW-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [COLS*PTS*CW-1:0]  out_data,
  output logic                    err_frame,
  output logic                    busy
);

  localparam int unsigned RW    = clog2(ROWS);
  localparam int unsigned VW    = clog2(ROWS + 1);
  localparam int unsigned NBEAT = OUTLEN / PTS;
  localparam int unsigned BW    = clog2(NBEAT);

  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [RW-1:0] r_wr_row;
  logic [BW-1:0] r_beat;
  logic          r_err;

  logic                   w_in_fire;
  logic                   w_last_row;
  logic                   w_close;
  logic                   w_out_fire;
  logic                   w_beat_last;
  logic                   w_release;
  logic [VW-1:0]          w_rows_valid;
  logic [COLS*PTS*CW-1:0] w_rd_data [2];

  assign in_ready     = !r_full[r_wr_bank];
  assign out_valid    = r_full[r_rd_bank];
  assign w_in_fire    = in_valid && in_ready;
  assign w_last_row   = (r_wr_row == RW'(ROWS - 1));
  assign w_close      = w_in_fire && (in_last || w_last_row);
  assign w_out_fire   = out_valid && out_ready;
  assign w_beat_last  = (r_beat == BW'(NBEAT - 1));
  assign w_release    = w_out_fire && w_beat_last;
  assign w_rows_valid = VW'(r_wr_row) + VW'(1);

  assign out_last  = out_valid && w_beat_last;
  assign out_data  = w_rd_data[r_rd_bank];
  assign err_frame = r_err;
  assign busy      = (|r_full) || (r_wr_row != '0);

  // Write side: row pointer, bank toggle on frame close, sticky framing error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_row  <= '0;
      r_wr_bank <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_in_fire) begin
      if (w_close) begin
        r_wr_row  <= '0;
        r_wr_bank <= !r_wr_bank;
      end else begin
        r_wr_row  <= r_wr_row + RW'(1);
      end
      if (in_last != w_last_row) r_err <= 1'b1;
    end
  end

  // Bank-full flags; close and release always target different banks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full <= '0;
    end else begin
      if (w_close)   r_full[r_wr_bank] <= 1'b1;
      if (w_release) r_full[r_rd_bank] <= 1'b0;
    end
  end

  // Read side: beat counter and bank toggle on the final beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat    <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_out_fire) begin
      if (w_beat_last) begin
        r_beat    <= '0;
        r_rd_bank <= !r_rd_bank;
      end else begin
        r_beat    <= r_beat + BW'(1);
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ct_bank #(
      .DATALEN (DATALEN),
      .ROWS    (ROWS),
      .COLS    (COLS),
      .OUTLEN  (OUTLEN),
      .PTS     (PTS)
    ) u_bank (
      .clk          (clk),
      .rstn         (rstn),
      .i_wr_en      (w_in_fire && (r_wr_bank == 1'(b))),
      .i_wr_row     (r_wr_row),
      .i_wr_data    (in_data),
      .i_close      (w_close && (r_wr_bank == 1'(b))),
      .i_rows_valid (w_rows_valid),
      .i_beat       (r_beat),
      .o_rd_data    (w_rd_data[b])
    );
  end

endmodule
